regbank_wb_ctrl: RTL and testbench
==================================

# regbank_wb_ctrl

Write-back controller for the 16 × 32-bit general-purpose register bank of the SH-1 core. It arbitrates the bank's single write port between the execute unit (EX) and the load unit (LD) with round-robin fairness. It drives the bank's registered write-enable, address and data. It keeps a per-register pending-write scoreboard that decode uses to stall on read-after-write hazards.

## Interface
Parameters:
- REG_WIDTH, 32, data width of one register
- REG_COUNT, 16, number of registers
- ADDR_W, 4, register address width (= $clog2(REG_COUNT))

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX write-back request
- ex_ready  out  1  EX request granted this cycle
- ex_addr  in  ADDR_W  EX destination register
- ex_data  in  REG_WIDTH  EX result
- ld_valid  in  1  LD write-back request
- ld_ready  out  1  LD request granted this cycle
- ld_addr  in  ADDR_W  LD destination register
- ld_data  in  REG_WIDTH  LD data
- sb_set_valid  in  1  decode reserves a future write to sb_set_addr
- sb_set_addr  in  ADDR_W  register being reserved
- sb_set_ready  out  1  reservation accepted (target counter not saturated)
- sb_busy  out  REG_COUNT  bit i = register i has at least one pending write
- sb_err  out  1  sticky: a commit hit a register with no reservation
- rb_we  out  1  register-bank write enable
- rb_waddr  out  ADDR_W  register-bank write address
- rb_wdata  out  REG_WIDTH  register-bank write data

## Operation
- Handshake: a transfer occurs when valid && ready. Requesters hold valid, addr and data stable until ready. ready is combinational from the valid inputs and the priority pointer only; it never depends on the ready outputs.
- Arbitration: at most one grant per cycle.
  - Only one requester valid: it is granted.
  - Both valid: the requester named by the priority pointer `prio` (0 = EX, 1 = LD) is granted.
  - After any grant, `prio` points to the other requester. With no grant, `prio` holds.
- Write register: on a granted cycle, rb_we <= 1, rb_waddr <= granted addr, rb_wdata <= granted data. Otherwise rb_we <= 0 and rb_waddr/rb_wdata hold their previous values.
- Scoreboard: each register has a 2-bit pending counter cnt[i]; sb_busy[i] = (cnt[i] != 0).
  - Set: sb_set_valid && sb_set_ready increments cnt[sb_set_addr].
  - Commit: rb_we == 1 decrements cnt[rb_waddr]. The decrement happens on the same edge at which the bank captures the data.
  - Set and commit to the same register in the same cycle: counter unchanged.
  - Set and commit to different registers: both applied.
- sb_set_ready = (cnt[sb_set_addr] != 3). It is combinational. A set while not ready is ignored, so the counter never overflows.
- Commit with cnt == 0: the counter stays 0 and sb_err is set. sb_err clears only on reset.
- Ordering: writes to the same register from EX and LD are committed in grant order. Issue must not rely on cross-unit ordering; the counter tracks how many writes are outstanding, not which unit produces them.

## Timing
- Reset values (asynchronous, immediate): rb_we=0, rb_waddr=0, rb_wdata=0, all cnt=0, sb_busy=0, sb_err=0, prio=0 (EX first).
- ex_ready, ld_ready and sb_set_ready are combinational. During reset ex_ready and ld_ready follow the combinational rule with prio=0.
- Grant-to-write latency: 1 cycle. A grant in cycle N gives rb_we=1 in cycle N+1, and the bank holds the new value from cycle N+2.
- Busy clear: sb_busy[i] drops in cycle N+2, the same cycle the bank read port returns the new value. Decode never sees busy low with stale data.
- Set-to-busy latency: a set in cycle N gives sb_busy high from cycle N+1.
- Throughput: one write per cycle sustained. With both requesters continuously valid, grants alternate EX, LD, EX, …
- Reset mid-operation: a registered write not yet committed is dropped (rb_we forced 0). Reservations are lost; the core flushes with the same reset.

## Test plan
- Reset then idle: all outputs 0, sb_busy=16'h0000. After release, ex_valid=1 alone gives ex_ready=1, ld_ready=0.
- Arbitration: EX (addr 3, 32'hAAAA0001) and LD (addr 5, 32'h55550002) both held valid 4 cycles. Required: grants EX, LD, EX, LD; rb_we=1 on the following 4 cycles, with waddr 3, 5, 3, 5.
- Scoreboard round-trip: set R7 in cycle 0 gives sb_busy[7]=1 from cycle 1. EX write R7 = 32'hDEADBEEF granted in cycle 3 gives rb_we in cycle 4 and sb_busy[7]=0 in cycle 5, sb_err=0.
- Saturation: three sets to R2 leave sb_set_ready=0 for addr 2; a fourth set is ignored. Three commits to R2 clear busy; sb_err stays 0.
- Simultaneous set and commit on R9 with cnt=1 leaves cnt at 1 and sb_busy[9]=1. A commit to R4 with cnt=0 sets sb_err=1, which stays set until rst_n.
- Reset asserted the cycle after an LD grant: rb_we=0 immediately, no write reaches the bank, and sb_busy clears.

Source files
------------

// File: rtl/regbank_wb_ctrl.sv
// Write-back controller for the SH-1 16x32 register bank: round-robin EX/LD
// arbitration onto the single write port plus a pending-write scoreboard.
module regbank_wb_ctrl #(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [ADDR_W-1:0]    ex_addr,
  input  logic [REG_WIDTH-1:0] ex_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [REG_WIDTH-1:0] ld_data,
  input  logic                 sb_set_valid,
  input  logic [ADDR_W-1:0]    sb_set_addr,
  output logic                 sb_set_ready,
  output logic [REG_COUNT-1:0] sb_busy,
  output logic                 sb_err,
  output logic                 rb_we,
  output logic [ADDR_W-1:0]    rb_waddr,
  output logic [REG_WIDTH-1:0] rb_wdata
);

  logic                 r_prio;
  logic                 r_we;
  logic [ADDR_W-1:0]    r_waddr;
  logic [REG_WIDTH-1:0] r_wdata;
  logic                 r_err;
  logic [1:0]           r_cnt      [REG_COUNT];
  logic [1:0]           w_cnt_next [REG_COUNT];

  logic                 w_grant_ex;
  logic                 w_grant_ld;
  logic                 w_set_fire;
  logic                 w_commit_err;
  logic [REG_COUNT-1:0] w_set_hit;
  logic [REG_COUNT-1:0] w_com_hit;

  // Grants depend only on the valids and the priority pointer.
  assign w_grant_ex = ex_valid && (!ld_valid || !r_prio);
  assign w_grant_ld = ld_valid && (!ex_valid ||  r_prio);
  assign ex_ready   = w_grant_ex;
  assign ld_ready   = w_grant_ld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (w_grant_ex) begin
      r_prio <= 1'b1;
    end else if (w_grant_ld) begin
      r_prio <= 1'b0;
    end
  end

  // Address/data hold their last value when no write is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_grant_ex || w_grant_ld;
      if (w_grant_ex) begin
        r_waddr <= ex_addr;
        r_wdata <= ex_data;
      end else if (w_grant_ld) begin
        r_waddr <= ld_addr;
        r_wdata <= ld_data;
      end
    end
  end

  assign rb_we    = r_we;
  assign rb_waddr = r_waddr;
  assign rb_wdata = r_wdata;

  assign sb_set_ready = (r_cnt[sb_set_addr] != 2'd3);
  assign w_set_fire   = sb_set_valid && sb_set_ready;
  assign w_commit_err = r_we && (r_cnt[r_waddr] == 2'd0);

  // Per-register pending counters; set and commit on the same register cancel.
  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_cnt
      assign w_set_hit[gi] = w_set_fire && (sb_set_addr == ADDR_W'(gi));
      assign w_com_hit[gi] = r_we && (r_waddr == ADDR_W'(gi));
      assign w_cnt_next[gi] =
          (w_set_hit[gi] && !w_com_hit[gi]) ? r_cnt[gi] + 2'd1 :
          (!w_set_hit[gi] && w_com_hit[gi] && (r_cnt[gi] != 2'd0)) ? r_cnt[gi] - 2'd1 :
          r_cnt[gi];
      assign sb_busy[gi] = (r_cnt[gi] != 2'd0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_cnt[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_commit_err) begin
      r_err <= 1'b1;
    end
  end

  assign sb_err = r_err;

endmodule

// File: tb/tb_regbank_wb_ctrl.sv
// Directed-vector bench for regbank_wb_ctrl: arbitration, write latency,
// scoreboard set/commit/saturation/error, and reset mid-operation.
module tb_regbank_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ld_valid, sb_set_valid;
  logic        ex_ready, ld_ready, sb_set_ready;
  logic [3:0]  ex_addr, ld_addr, sb_set_addr;
  logic [31:0] ex_data, ld_data;
  logic [15:0] sb_busy;
  logic        sb_err;
  logic        rb_we;
  logic [3:0]  rb_waddr;
  logic [31:0] rb_wdata;

  int checks = 0;
  int errors = 0;
  int cycles = 0;

  regbank_wb_ctrl #(.REG_WIDTH(32), .REG_COUNT(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .sb_set_valid(sb_set_valid), .sb_set_addr(sb_set_addr), .sb_set_ready(sb_set_ready),
    .sb_busy(sb_busy), .sb_err(sb_err),
    .rb_we(rb_we), .rb_waddr(rb_waddr), .rb_wdata(rb_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycles++;
    if (cycles > 20000) begin
      $display("FAIL watchdog cycles=%0d limit=20000", cycles);
      $fatal(1, "watchdog expired");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input logic [3:0] a);
    sb_set_valid = 1'b1;
    sb_set_addr  = a;
    tick();
    sb_set_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ex_valid = 0; ld_valid = 0; sb_set_valid = 0;
    ex_addr = 0; ld_addr = 0; sb_set_addr = 0; ex_data = 0; ld_data = 0;
    #3;
    checks++; if (rb_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", rb_we); end
    checks++; if (rb_waddr !== 4'd0) begin errors++; $display("FAIL rst_waddr got %0d exp 0", rb_waddr); end
    checks++; if (rb_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata got %h exp 0", rb_wdata); end
    checks++; if (sb_busy !== 16'h0000) begin errors++; $display("FAIL rst_busy got %h exp 0000", sb_busy); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", sb_err); end
    checks++; if (sb_set_ready !== 1'b1) begin errors++; $display("FAIL rst_set_ready got %0b exp 1", sb_set_ready); end
    ex_valid = 1; ld_valid = 1; #1;
    checks++; if (ex_ready !== 1'b1 || ld_ready !== 1'b0) begin errors++; $display("FAIL rst_prio got ex=%0b ld=%0b exp ex=1 ld=0", ex_ready, ld_ready); end
    ex_valid = 0; ld_valid = 0;
    tick();
    rst_n = 1'b1;
    tick();
    ex_valid = 1; #1;
    checks++; if (ex_ready !== 1'b1 || ld_ready !== 1'b0) begin errors++; $display("FAIL idle_ex_only got ex=%0b ld=%0b exp ex=1 ld=0", ex_ready, ld_ready); end
    ex_valid = 0; #1;
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL idle_none got ex=%0b exp 0", ex_ready); end
    $display("txn reset/idle done");
  endtask

  task automatic test_arbitration();
    logic       exp_ex;
    logic [3:0] exp_addr;
    logic [31:0] exp_data;
    set_reg(4'd3); set_reg(4'd3); set_reg(4'd5); set_reg(4'd5);
    checks++; if (sb_busy !== 16'h0028) begin errors++; $display("FAIL arb_reserve got %h exp 0028", sb_busy); end
    ex_valid = 1; ex_addr = 4'd3; ex_data = 32'hAAAA0001;
    ld_valid = 1; ld_addr = 4'd5; ld_data = 32'h55550002;
    for (int k = 0; k < 4; k++) begin
      exp_ex   = (k % 2 == 0);
      exp_addr = exp_ex ? 4'd3 : 4'd5;
      exp_data = exp_ex ? 32'hAAAA0001 : 32'h55550002;
      #1;
      checks++; if (ex_ready !== exp_ex || ld_ready !== !exp_ex) begin errors++; $display("FAIL arb_grant%0d got ex=%0b ld=%0b exp ex=%0b ld=%0b", k, ex_ready, ld_ready, exp_ex, !exp_ex); end
      tick();
      if (k == 3) begin ex_valid = 0; ld_valid = 0; end
      checks++; if (rb_we !== 1'b1 || rb_waddr !== exp_addr || rb_wdata !== exp_data) begin errors++; $display("FAIL arb_write%0d got we=%0b a=%0d d=%h exp we=1 a=%0d d=%h", k, rb_we, rb_waddr, rb_wdata, exp_addr, exp_data); end
      $display("txn arb grant %0d %s addr=%0d data=%h", k, exp_ex ? "EX" : "LD", rb_waddr, rb_wdata);
    end
    tick();
    checks++; if (rb_we !== 1'b0 || rb_waddr !== 4'd5 || rb_wdata !== 32'h55550002) begin errors++; $display("FAIL arb_hold got we=%0b a=%0d d=%h exp we=0 a=5 d=55550002", rb_we, rb_waddr, rb_wdata); end
    checks++; if (sb_busy !== 16'h0000 || sb_err !== 1'b0) begin errors++; $display("FAIL arb_sb got busy=%h err=%0b exp 0000 0", sb_busy, sb_err); end
  endtask

  task automatic test_scoreboard();
    sb_set_valid = 1; sb_set_addr = 4'd7; #1;
    checks++; if (sb_set_ready !== 1'b1) begin errors++; $display("FAIL sb_set_ready got %0b exp 1", sb_set_ready); end
    tick(); sb_set_valid = 0;
    checks++; if (sb_busy[7] !== 1'b1) begin errors++; $display("FAIL sb_busy_c1 got %0b exp 1", sb_busy[7]); end
    tick(); tick();
    ex_valid = 1; ex_addr = 4'd7; ex_data = 32'hDEADBEEF; #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL sb_ex_grant got %0b exp 1", ex_ready); end
    tick(); ex_valid = 0;
    checks++; if (rb_we !== 1'b1 || rb_waddr !== 4'd7 || rb_wdata !== 32'hDEADBEEF || sb_busy[7] !== 1'b1) begin errors++; $display("FAIL sb_c4 got we=%0b a=%0d d=%h busy=%0b exp 1 7 deadbeef 1", rb_we, rb_waddr, rb_wdata, sb_busy[7]); end
    tick();
    checks++; if (sb_busy[7] !== 1'b0 || sb_err !== 1'b0) begin errors++; $display("FAIL sb_c5 got busy=%0b err=%0b exp 0 0", sb_busy[7], sb_err); end
    $display("txn scoreboard R7 round-trip");
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      sb_set_valid = 1; sb_set_addr = 4'd2; #1;
      checks++; if (sb_set_ready !== 1'b1) begin errors++; $display("FAIL sat_ready%0d got %0b exp 1", k, sb_set_ready); end
      tick();
    end
    checks++; if (sb_set_ready !== 1'b0) begin errors++; $display("FAIL sat_full got %0b exp 0", sb_set_ready); end
    tick(); sb_set_valid = 0;
    checks++; if (sb_busy[2] !== 1'b1) begin errors++; $display("FAIL sat_busy got %0b exp 1", sb_busy[2]); end
    ld_valid = 1; ld_addr = 4'd2;
    for (int k = 0; k < 3; k++) begin
      ld_data = 32'h1000 + k; #1;
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL sat_ld_grant%0d got %0b exp 1", k, ld_ready); end
      tick();
      $display("txn sat commit %0d addr=2", k);
    end
    ld_valid = 0;
    checks++; if (sb_busy[2] !== 1'b1 || sb_set_ready !== 1'b1) begin errors++; $display("FAIL sat_cnt1 got busy=%0b rdy=%0b exp 1 1", sb_busy[2], sb_set_ready); end
    tick();
    checks++; if (sb_busy[2] !== 1'b0 || sb_err !== 1'b0) begin errors++; $display("FAIL sat_clear got busy=%0b err=%0b exp 0 0", sb_busy[2], sb_err); end
  endtask

  task automatic test_set_commit_err();
    set_reg(4'd9);
    ex_valid = 1; ex_addr = 4'd9; ex_data = 32'h99; tick(); ex_valid = 0;
    sb_set_valid = 1; sb_set_addr = 4'd9;
    checks++; if (rb_we !== 1'b1 || rb_waddr !== 4'd9) begin errors++; $display("FAIL sc_write got we=%0b a=%0d exp 1 9", rb_we, rb_waddr); end
    tick(); sb_set_valid = 0;
    checks++; if (sb_busy[9] !== 1'b1) begin errors++; $display("FAIL sc_busy got %0b exp 1", sb_busy[9]); end
    ex_valid = 1; tick(); ex_valid = 0; tick();
    checks++; if (sb_busy[9] !== 1'b0 || sb_err !== 1'b0) begin errors++; $display("FAIL sc_cnt1 got busy=%0b err=%0b exp 0 0", sb_busy[9], sb_err); end
    $display("txn set+commit R9");
    ex_valid = 1; ex_addr = 4'd4; ex_data = 32'h44; tick(); ex_valid = 0; tick();
    checks++; if (sb_err !== 1'b1 || sb_busy[4] !== 1'b0) begin errors++; $display("FAIL err_set got err=%0b busy=%0b exp 1 0", sb_err, sb_busy[4]); end
    tick(); tick(); tick();
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b exp 1", sb_err); end
    $display("txn orphan commit R4");
  endtask

  task automatic test_reset_midop();
    set_reg(4'd6);
    ld_valid = 1; ld_addr = 4'd6; ld_data = 32'h12345678;
    tick(); ld_valid = 0;
    checks++; if (rb_we !== 1'b1 || sb_busy[6] !== 1'b1) begin errors++; $display("FAIL mid_pre got we=%0b busy=%0b exp 1 1", rb_we, sb_busy[6]); end
    rst_n = 1'b0; #1;
    checks++; if (rb_we !== 1'b0 || rb_wdata !== 32'd0 || sb_busy !== 16'h0 || sb_err !== 1'b0) begin errors++; $display("FAIL mid_rst got we=%0b d=%h busy=%h err=%0b exp 0 0 0 0", rb_we, rb_wdata, sb_busy, sb_err); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (rb_we !== 1'b0 || rb_wdata !== 32'd0 || sb_busy !== 16'h0 || sb_err !== 1'b0) begin errors++; $display("FAIL mid_after got we=%0b d=%h busy=%h err=%0b exp 0 0 0 0", rb_we, rb_wdata, sb_busy, sb_err); end
    $display("txn reset mid-operation");
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_scoreboard();
    test_saturation();
    test_set_commit_err();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
